// File: rtl/counter_arbiter.sv
// Two-requester arbiter issuing load/increment commands to a shared 8-bit counter.
// Latency: request sampled at edge N -> grant/command in cycle N+1 -> rsp_valid in cycle N+3.
// Backpressure: one operation per 3 cycles; requests are only sampled in IDLE.
// Optional feature: define ROUND_ROBIN_EN for round-robin contention resolution
// (default build uses fixed priority, A wins).
module counter_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       op_a,
  input  logic       op_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic [7:0] cnt_value,
  output logic [7:0] load,
  output logic       load_enable,
  output logic       increment,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_value,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       winner_q, winner_d;
  logic [7:0] load_q, load_d;
  logic       load_enable_q, load_enable_d;
  logic       increment_q, increment_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_value_q, rsp_value_d;

  logic       pick_b;
  logic       sel_op;
  logic [7:0] sel_data;

`ifdef ROUND_ROBIN_EN
  logic       prefer_b_q, prefer_b_d;

  // Winner selection: on contention the requester not granted most recently wins.
  always_comb begin
    pick_b = 1'b0;
    if (req_a && req_b) begin
      pick_b = prefer_b_q;
    end else begin
      pick_b = req_b;
    end
  end

  // Pointer moves only when a grant is actually issued.
  always_comb begin
    prefer_b_d = prefer_b_q;
    if (state_q == IDLE && (req_a || req_b)) begin
      prefer_b_d = ~pick_b;
    end
  end

  // Pointer register; reset prefers A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_b_q <= 1'b0;
    end else begin
      prefer_b_q <= prefer_b_d;
    end
  end
`else
  // Winner selection: fixed priority, B only wins when A is not requesting.
  always_comb begin
    pick_b = 1'b0;
    pick_b = req_b & ~req_a;
  end
`endif

  // Operation and load data of the selected requester.
  always_comb begin
    sel_op   = pick_b ? op_b : op_a;
    sel_data = pick_b ? data_b : data_a;
  end

  // Next-state and registered-output logic; command outputs are pulses that
  // are only set on the IDLE->ISSUE transition and cleared otherwise.
  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    load_d        = 8'h00;
    load_enable_d = 1'b0;
    increment_d   = 1'b0;
    gnt_a_d       = 1'b0;
    gnt_b_d       = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_value_d   = rsp_value_q;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d       = ISSUE;
          winner_d      = pick_b;
          load_enable_d = sel_op;
          increment_d   = ~sel_op;
          load_d        = sel_op ? sel_data : 8'h00;
          gnt_a_d       = ~pick_b;
          gnt_b_d       = pick_b;
        end
      end
      ISSUE: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        // Counter has absorbed the command by now; capture its result.
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = winner_q;
        rsp_value_d = cnt_value;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      winner_q      <= 1'b0;
      load_q        <= 8'h00;
      load_enable_q <= 1'b0;
      increment_q   <= 1'b0;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_value_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      load_q        <= load_d;
      load_enable_q <= load_enable_d;
      increment_q   <= increment_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_value_q   <= rsp_value_d;
    end
  end

  assign load        = load_q;
  assign load_enable = load_enable_q;
  assign increment   = increment_q;
  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_value   = rsp_value_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural model of the shared counter.
module tb_counter_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a, req_b, op_a, op_b;
  logic [7:0] data_a, data_b;
  logic [7:0] cnt_value;
  logic [7:0] load;
  logic       load_enable, increment, gnt_a, gnt_b;
  logic       rsp_valid, rsp_id, busy;
  logic [7:0] rsp_value;

  int n_checks = 0;
  int n_fail   = 0;

  counter_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .data_a(data_a), .data_b(data_b), .cnt_value(cnt_value),
    .load(load), .load_enable(load_enable), .increment(increment),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_value(rsp_value),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared counter driven by the arbiter's commands.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_value <= 8'h00;
    else if (load_enable) cnt_value <= load;
    else if (increment) cnt_value <= cnt_value + 8'h01;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 0; req_b = 0; op_a = 0; op_b = 0; data_a = 8'h00; data_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({load, load_enable, increment, gnt_a, gnt_b, rsp_valid, rsp_id, rsp_value, busy} !== 23'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {load, load_enable, increment, gnt_a, gnt_b, rsp_valid, rsp_id, rsp_value, busy});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    req_a = 1; op_a = 1; data_a = 8'h3C;
    step();
    n_checks++;
    if ({gnt_a, gnt_b, load_enable, increment, load, busy} !== {4'b1010, 8'h3C, 1'b1}) begin
      n_fail++; $display("FAIL load_issue: got %b want %b", {gnt_a, gnt_b, load_enable, increment, load, busy}, {4'b1010, 8'h3C, 1'b1});
    end
    req_a = 0;
    step();
    n_checks++;
    if ({gnt_a, load_enable, increment, load, rsp_valid, busy} !== {3'b000, 8'h00, 2'b01}) begin
      n_fail++; $display("FAIL load_settle: got %b want %b", {gnt_a, load_enable, increment, load, rsp_valid, busy}, {3'b000, 8'h00, 2'b01});
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_value, busy} !== {2'b10, 8'h3C, 1'b0}) begin
      n_fail++; $display("FAIL load_rsp: got %b want %b", {rsp_valid, rsp_id, rsp_value, busy}, {2'b10, 8'h3C, 1'b0});
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_rsp_pulse: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_wrap();
    req_a = 1; op_a = 1; data_a = 8'hFF;
    step();
    req_a = 0;
    step();
    step();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_value} !== {2'b10, 8'hFF}) begin
      n_fail++; $display("FAIL wrap_preload: got %b want %b", {rsp_valid, rsp_id, rsp_value}, {2'b10, 8'hFF});
    end
    req_b = 1; op_b = 0; data_b = 8'h77;
    step();
    n_checks++;
    if ({gnt_a, gnt_b, load_enable, increment, load} !== {4'b0101, 8'h00}) begin
      n_fail++; $display("FAIL wrap_issue: got %b want %b", {gnt_a, gnt_b, load_enable, increment, load}, {4'b0101, 8'h00});
    end
    req_b = 0;
    step();
    step();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_value} !== {2'b11, 8'h00}) begin
      n_fail++; $display("FAIL wrap_rsp: got %b want %b", {rsp_valid, rsp_id, rsp_value}, {2'b11, 8'h00});
    end
  endtask

  task automatic test_contention();
    logic exp_b;
    req_a = 1; req_b = 1; op_a = 0; op_b = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef ROUND_ROBIN_EN
      exp_b = (i % 2) == 1;
`else
      exp_b = 1'b0;
`endif
      step();
      n_checks++;
      if ({gnt_a, gnt_b, increment, load_enable} !== {~exp_b, exp_b, 2'b10}) begin
        n_fail++; $display("FAIL contention_grant[%0d]: got %b want %b", i, {gnt_a, gnt_b, increment, load_enable}, {~exp_b, exp_b, 2'b10});
      end
      step();
      step();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_value} !== {1'b1, exp_b, 8'(i + 1)}) begin
        n_fail++; $display("FAIL contention_rsp[%0d]: got %b want %b", i, {rsp_valid, rsp_id, rsp_value}, {1'b1, exp_b, 8'(i + 1)});
      end
    end
    req_a = 0;
    step();
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      n_fail++; $display("FAIL contention_b_after_a: got %b want 01", {gnt_a, gnt_b});
    end
    req_b = 0;
    step();
    step();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_value} !== {2'b11, 8'h07}) begin
      n_fail++; $display("FAIL contention_b_rsp: got %b want %b", {rsp_valid, rsp_id, rsp_value}, {2'b11, 8'h07});
    end
  endtask

  task automatic test_reset_mid_issue();
    req_a = 1; op_a = 1; data_a = 8'h55;
    step();
    n_checks++;
    if ({gnt_a, load_enable} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_issue: got %b want 11", {gnt_a, load_enable});
    end
    #2 rst = 1'b1;
    req_a = 0;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b, load_enable, increment, load, busy} !== 13'h0) begin
      n_fail++; $display("FAIL midrst_async: got %b want 0", {gnt_a, gnt_b, load_enable, increment, load, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, gnt_a, gnt_b, busy} !== 4'b0000) begin
        n_fail++; $display("FAIL midrst_quiet[%0d]: got %b want 0000", i, {rsp_valid, gnt_a, gnt_b, busy});
      end
    end
    req_b = 1; op_b = 0;
    step();
    n_checks++;
    if ({gnt_b, increment} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_next_issue: got %b want 11", {gnt_b, increment});
    end
    req_b = 0;
    step();
    step();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_value} !== {2'b11, 8'h01}) begin
      n_fail++; $display("FAIL midrst_next_rsp: got %b want %b", {rsp_valid, rsp_id, rsp_value}, {2'b11, 8'h01});
    end
  endtask

  task automatic test_withdraw();
    req_b = 1; op_b = 0;
    step();
    req_b = 0;
    step();
    req_a = 1; op_a = 1; data_a = 8'hAA;
    #2 req_a = 0;
    step();
    n_checks++;
    if ({busy, rsp_valid, rsp_id, rsp_value} !== {3'b011, 8'h02}) begin
      n_fail++; $display("FAIL withdraw_rsp: got %b want %b", {busy, rsp_valid, rsp_id, rsp_value}, {3'b011, 8'h02});
    end
    step();
    n_checks++;
    if ({gnt_a, gnt_b, load_enable, increment, busy, rsp_valid} !== 6'b0) begin
      n_fail++; $display("FAIL withdraw_no_grant: got %b want 0", {gnt_a, gnt_b, load_enable, increment, busy, rsp_valid});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_contention();
    test_reset_mid_issue();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
